// File: rtl/booth2_final_adder_pipe_pkg.sv
// Shared widths and operand alignment for the Booth2 final adder.
// Imported by the interface, the adder slice and the pipeline top.
package booth2_final_adder_pipe_pkg;

   localparam int PROD_W    = 32;
   localparam int PP2_W     = 30;
   localparam int PP2_SHIFT = 2;

   // pp2 carries weight 2^2 at its bit 0
   function automatic logic [PROD_W-1:0] align_pp2(
      input logic [PP2_W-1:0] pp2
   );
      return {pp2, {PP2_SHIFT{1'b0}}};
   endfunction

endpackage

// File: rtl/booth2_final_adder_pipe_if.sv
// Valid/ready bus for the final adder: operand side and product side.
// The pipeline takes the slave view, its environment the master view.
interface booth2_final_adder_pipe_if
   import booth2_final_adder_pipe_pkg::*;
#(
   parameter int TAG_W = 4
);

   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] pp1;
   logic [PP2_W-1:0]  pp2;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [PROD_W-1:0] product;
   logic [TAG_W-1:0]  out_tag;

   modport slave (
      input  in_valid, pp1, pp2, in_tag, out_ready,
      output in_ready, out_valid, product, out_tag
   );

   modport master (
      output in_valid, pp1, pp2, in_tag, out_ready,
      input  in_ready, out_valid, product, out_tag
   );

endinterface

// File: rtl/booth2_final_adder_pipe_adder_slice.sv
// Combinational W-bit adder with carry in and carry out.
// Used for both halves of the split carry-propagate add.
module adder_slice #(
   parameter int W = 16
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         ci_i,
   output logic [W-1:0] s_o,
   output logic         co_o
);

   assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};

endmodule

// File: rtl/booth2_final_adder_pipe.sv
// Two-stage split-carry adder: pp1 + (pp2 << 2) mod 2^32.
// Low LO_W bits add in stage 1, the rest plus carry in stage 2.
module booth2_final_adder_pipe
   import booth2_final_adder_pipe_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int LO_W  = 16
) (
   input logic sys_clk,
   input logic sys_rst_n,
   booth2_final_adder_pipe_if.slave bus
);

   localparam int HI_W = PROD_W - LO_W;

   logic [PROD_W-1:0] b_full;
   logic              s1_adv;
   logic              s2_adv;

   logic [LO_W-1:0]   lo_sum_d;
   logic              lo_co_d;
   logic [HI_W-1:0]   hi_sum_d;
   logic              hi_co_unused;

   logic              s1_valid_q;
   logic [LO_W-1:0]   s1_lo_q;
   logic              s1_c_q;
   logic [HI_W-1:0]   s1_hi_a_q;
   logic [HI_W-1:0]   s1_hi_b_q;
   logic [TAG_W-1:0]  s1_tag_q;

   logic              out_valid_q;
   logic [PROD_W-1:0] product_q;
   logic [TAG_W-1:0]  out_tag_q;

   assign b_full = align_pp2(bus.pp2);

   assign s2_adv = ~out_valid_q | bus.out_ready;
   assign s1_adv = ~s1_valid_q | s2_adv;

   adder_slice #(.W(LO_W)) u_lo (
      .a_i  (bus.pp1[LO_W-1:0]),
      .b_i  (b_full[LO_W-1:0]),
      .ci_i (1'b0),
      .s_o  (lo_sum_d),
      .co_o (lo_co_d)
   );

   adder_slice #(.W(HI_W)) u_hi (
      .a_i  (s1_hi_a_q),
      .b_i  (s1_hi_b_q),
      .ci_i (s1_c_q),
      .s_o  (hi_sum_d),
      .co_o (hi_co_unused)
   );

   // Stage 1: low-half sum and carry, high operands parked for stage 2
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_lo_q    <= '0;
         s1_c_q     <= 1'b0;
         s1_hi_a_q  <= '0;
         s1_hi_b_q  <= '0;
         s1_tag_q   <= '0;
      end else if (s1_adv) begin
         s1_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            s1_lo_q   <= lo_sum_d;
            s1_c_q    <= lo_co_d;
            s1_hi_a_q <= bus.pp1[PROD_W-1:LO_W];
            s1_hi_b_q <= b_full[PROD_W-1:LO_W];
            s1_tag_q  <= bus.in_tag;
         end
      end
   end

   // Stage 2: high-half sum with stage-1 carry, product held under stall
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         out_valid_q <= 1'b0;
         product_q   <= '0;
         out_tag_q   <= '0;
      end else if (s2_adv) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            product_q <= {hi_sum_d, s1_lo_q};
            out_tag_q <= s1_tag_q;
         end
      end
   end

   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = out_valid_q;
   assign bus.product   = product_q;
   assign bus.out_tag   = out_tag_q;

endmodule
